game_flow_ctrl: RTL

Parametrised game-flow controller; next generation of the top-level game state machine. Replaces the fixed START/LEVEL_1/FINISH flow with:
- N-player finish detection and N-level progression
- per-level timeout and pause/resume
- edge-detected buttons and an inter-level hold phase
Sits between input/mouse/GPIO glue and the draw/player modules, which consume game_state and level.

---
 rtl/game_flow_ctrl_pkg.sv | 26 ++
 rtl/game_flow_ctrl_btn_edge.sv | 26 ++
 rtl/game_flow_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/game_flow_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | game_flow_ctrl_pkg                                                          |
// | Shared game-state encoding, playfield constants and width helper.           |
// | Rev 1.0 - initial N-level / timeout / pause release                          |
// +----------------------------------------------------------------------------+
package game_flow_ctrl_pkg;

  // START must stay at encoding 0 so a cleared register means "menu".
  typedef enum logic [2:0] {
    START      = 3'd0,
    PLAY       = 3'd1,
    PAUSED     = 3'd2,
    LEVEL_DONE = 3'd3,
    FINISH     = 3'd4,
    TIMEOUT    = 3'd5
  } g_state;

  localparam int unsigned FINISH_X_DEFAULT = 980;

  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage
`default_nettype wire

// File: rtl/game_flow_ctrl_btn_edge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | game_flow_ctrl_btn_edge                                                     |
// | Rising-edge detector; history resets high so a held button is not an event. |
// | Rev 1.0 - initial release                                                    |
// +----------------------------------------------------------------------------+
module game_flow_ctrl_btn_edge #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_btn,
  output logic [W-1:0] o_rise
);

  logic [W-1:0] r_hist;

  always_ff @(posedge clk) begin
    if (rst) r_hist <= '1;
    else     r_hist <= i_btn;
  end

  assign o_rise = i_btn & ~r_hist;

endmodule
`default_nettype wire

// File: rtl/game_flow_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | game_flow_ctrl                                                              |
// | Top-level game flow: menu, N levels, per-level timeout, pause, hold phase.  |
// | Rev 1.0 - initial release                                                    |
// +----------------------------------------------------------------------------+
module game_flow_ctrl
  import game_flow_ctrl_pkg::*;
#(
  parameter int          N_PLAYERS   = 2,
  parameter int          N_LEVELS    = 3,
  parameter int          XW          = 12,
  parameter int unsigned FINISH_X    = FINISH_X_DEFAULT,
  parameter int unsigned LVL_TIMEOUT = 0,
  parameter int unsigned HOLD_CYC    = 65_000_000,
  localparam int LW = clog2_min1(N_LEVELS),
  localparam int TW = clog2_min1(LVL_TIMEOUT + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    m_left,
  input  logic                    m_right,
  input  logic                    gpio,
  input  logic                    pause,
  input  logic [N_PLAYERS*XW-1:0] xpos,
  output g_state                  game_state,
  output logic [LW-1:0]           level,
  output logic                    level_start,
  output logic [TW-1:0]           time_left,
  output logic [N_PLAYERS-1:0]    players_done
);

  localparam int HW = clog2_min1(HOLD_CYC);

  localparam logic [TW-1:0] c_TL_RELOAD = TW'(LVL_TIMEOUT);
  localparam logic [LW-1:0] c_LAST_LVL  = LW'(N_LEVELS - 1);
  localparam logic [HW-1:0] c_HOLD_LAST = HW'(HOLD_CYC - 1);
  localparam logic          c_TO_EN     = (LVL_TIMEOUT != 0);

  logic [3:0]           w_ev;
  logic                 w_ml_ev, w_mr_ev, w_gpio_ev, w_pause_ev;
  logic [N_PLAYERS-1:0] w_done_vec;
  logic                 w_all_done;

  g_state               r_state;
  logic [LW-1:0]        r_level;
  logic                 r_level_start;
  logic [TW-1:0]        r_time_left;
  logic [N_PLAYERS-1:0] r_players_done;
  logic [HW-1:0]        r_hold;

  game_flow_ctrl_btn_edge #(.W(4)) u_btn_edge (
    .clk    (clk),
    .rst    (rst),
    .i_btn  ({pause, gpio, m_right, m_left}),
    .o_rise (w_ev)
  );

  assign w_ml_ev    = w_ev[0];
  assign w_mr_ev    = w_ev[1];
  assign w_gpio_ev  = w_ev[2];
  assign w_pause_ev = w_ev[3];

  for (genvar gi = 0; gi < N_PLAYERS; gi++) begin : g_cmp
    assign w_done_vec[gi] = (32'(xpos[gi*XW +: XW]) >= FINISH_X);
  end

  assign w_all_done = &w_done_vec;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= START;
      r_level        <= '0;
      r_level_start  <= 1'b0;
      r_time_left    <= '0;
      r_players_done <= '0;
      r_hold         <= '0;
    end else begin
      r_level_start  <= 1'b0;
      r_players_done <= w_done_vec;
      case (r_state)
        START: begin
          if (w_ml_ev | w_gpio_ev) begin
            r_state       <= PLAY;
            r_level       <= '0;
            r_time_left   <= c_TL_RELOAD;
            r_level_start <= 1'b1;
          end
        end
        PLAY: begin
          // Finishing on the expiry cycle counts as a finish, not a timeout.
          if (w_all_done) begin
            r_state <= LEVEL_DONE;
            r_hold  <= '0;
          end else if (c_TO_EN && (r_time_left == TW'(1))) begin
            r_state     <= TIMEOUT;
            r_time_left <= '0;
          end else if (w_mr_ev) begin
            r_state <= START;
          end else if (w_pause_ev) begin
            r_state <= PAUSED;
          end else if (c_TO_EN && (r_time_left != '0)) begin
            r_time_left <= r_time_left - TW'(1);
          end
        end
        PAUSED: begin
          if (w_mr_ev)         r_state <= START;
          else if (w_pause_ev) r_state <= PLAY;
        end
        LEVEL_DONE: begin
          if (r_hold == c_HOLD_LAST) begin
            if (r_level == c_LAST_LVL) begin
              r_state <= FINISH;
            end else begin
              r_state       <= PLAY;
              r_level       <= r_level + LW'(1);
              r_time_left   <= c_TL_RELOAD;
              r_level_start <= 1'b1;
            end
          end else begin
            r_hold <= r_hold + HW'(1);
          end
        end
        FINISH, TIMEOUT: begin
          if (w_mr_ev) begin
            r_state     <= START;
            r_level     <= '0;
            r_time_left <= '0;
          end
        end
        default: r_state <= START;
      endcase
    end
  end

  assign game_state   = r_state;
  assign level        = r_level;
  assign level_start  = r_level_start;
  assign time_left    = r_time_left;
  assign players_done = r_players_done;

endmodule
`default_nettype wire
